// File: rtl/regfile_init.sv
// -----------------------------------------------------------------------------
// regfile_init
//
// 32 x 32-bit integer register file (x0..x31) that clears itself after reset.
// Once reset is released, a clear sequence walks x1..x31 one per clock, writing
// zero everywhere except x2 (sp), which gets SP_INIT. When x31 has been
// written, the file reports ready and accepts ordinary writes from the
// write port. x0 always reads as zero and ignores writes.
//
// Only the sequencer (state + counter) is on the reset net; the storage array
// is not, which is why the clear sequence exists at all.
//
// Parameters
//   SP_INIT  value placed in x2 by the clear sequence
//   BYPASS   1: a write in flight is forwarded to a matching read port in the
//               same cycle (write-through); 0: reads show the stored value
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   rst_n  in   1   asynchronous active-low reset
//   rs1    in   5   read address, port A
//   rs2    in   5   read address, port B
//   rd     in   5   write address
//   wd     in  32   write data
//   we     in   1   write enable (ignored until ready)
//   rd1    out 32   read data, port A (zero while not ready)
//   rd2    out 32   read data, port B (zero while not ready)
//   ready  out  1   clear sequence complete, file usable
// -----------------------------------------------------------------------------
module regfile_init #(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [4:0] LAST_REG = 5'd31;
    localparam logic [4:0] SP_REG   = 5'd2;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    // Single internal write port shared by the clear sequencer and the
    // external write port; which one owns it depends on the state.
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem_q [0:31];

    logic        fwd_en;

    // -------------------------------------------------------------------------
    // Sequencer state register
    // -------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and write-port arbitration
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = 32'h0;

        unique case (state_q)
            ST_CLEAR: begin
                // External writes are ignored here; the sequencer owns the port.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = (cnt_q == SP_REG) ? SP_INIT : 32'h0;
                // Hold the counter at x31 on the final edge instead of letting
                // it wrap to x0; the state change ends the sequence.
                if (cnt_q == LAST_REG) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            ST_READY: begin
                if (we && (rd != 5'd0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = rd;
                    mem_wdata = wd;
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately left off the reset net so it maps onto
    // plain flops/RAM without reset muxes; the clear sequence initialises it.
    // Entry 0 is never written and never read (reads of x0 are forced to 0).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready = (state_q == ST_READY);

    // Forwarding applies only to a write that will actually land this edge.
    assign fwd_en = BYPASS && ready && we && (rd != 5'd0);

    // -------------------------------------------------------------------------
    // Read port A
    // -------------------------------------------------------------------------
    always_comb begin
        rd1 = 32'h0;
        if (ready && (rs1 != 5'd0)) begin
            if (fwd_en && (rd == rs1)) begin
                rd1 = wd;
            end else begin
                rd1 = mem_q[rs1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read port B
    // -------------------------------------------------------------------------
    always_comb begin
        rd2 = 32'h0;
        if (ready && (rs2 != 5'd0)) begin
            if (fwd_en && (rd == rs2)) begin
                rd2 = wd;
            end else begin
                rd2 = mem_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_init.sv
// -----------------------------------------------------------------------------
// tb_regfile_init
//
// Directed bench for regfile_init. Two instances share every input: u_dut with
// forwarding enabled and u_nb with forwarding disabled, so the write-through
// behaviour of both variants is exercised by the same stimulus.
// -----------------------------------------------------------------------------
module tb_regfile_init;

    localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        we;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        ready_b, ready_n;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_init #(.SP_INIT(SP_VAL), .BYPASS(1'b1)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rs1  (rs1),
        .rs2  (rs2),
        .rd   (rd),
        .wd   (wd),
        .we   (we),
        .rd1  (rd1_b),
        .rd2  (rd2_b),
        .ready(ready_b)
    );

    regfile_init #(.SP_INIT(SP_VAL), .BYPASS(1'b0)) u_nb (
        .clk  (clk),
        .rst_n(rst_n),
        .rs1  (rs1),
        .rs2  (rs2),
        .rd   (rd),
        .wd   (wd),
        .we   (we),
        .rd1  (rd1_n),
        .rd2  (rd2_n),
        .ready(ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Release reset between edges, then step through the clear sequence
    // checking that ready stays low for 30 edges and rises on the 31st.
    task automatic run_clear(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            if (e == 30) begin
                check({tag, " ready_b@30"}, {31'b0, ready_b}, 32'h0);
                check({tag, " ready_n@30"}, {31'b0, ready_n}, 32'h0);
            end
            if (e == 31) begin
                check({tag, " ready_b@31"}, {31'b0, ready_b}, 32'h1);
                check({tag, " ready_n@31"}, {31'b0, ready_n}, 32'h1);
            end
            if (e < 30) begin
                check({tag, " ready_b early"}, {31'b0, ready_b}, 32'h0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rs1   = 5'd2;
        rs2   = 5'd5;
        rd    = 5'd0;
        wd    = 32'h0;
        we    = 1'b0;

        // Reset state
        #1;
        check("rst ready", {31'b0, ready_b}, 32'h0);
        check("rst rd1", rd1_b, 32'h0);
        check("rst rd2", rd2_b, 32'h0);

        // Clean clear sequence; outputs gated while not ready
        run_clear("clr1");
        check("sp rd1 b", rd1_b, SP_VAL);
        check("sp rd1 n", rd1_n, SP_VAL);
        check("x5 rd2 b", rd2_b, 32'h0);
        check("x5 rd2 n", rd2_n, 32'h0);

        // Ordinary write to x5
        @(negedge clk);
        we = 1'b1; rd = 5'd5; wd = 32'h0000_000F;
        @(posedge clk); #1;
        we = 1'b0; rs1 = 5'd5;
        #1;
        check("x5 rd1 b", rd1_b, 32'h0000_000F);
        check("x5 rd1 n", rd1_n, 32'h0000_000F);

        // Write to x31 with all-ones
        @(negedge clk);
        we = 1'b1; rd = 5'd31; wd = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        we = 1'b0; rs2 = 5'd31;
        #1;
        check("x31 rd2 b", rd2_b, 32'hFFFF_FFFF);
        check("x31 rd2 n", rd2_n, 32'hFFFF_FFFF);
        check("x5 kept", rd1_b, 32'h0000_000F);

        // Write to x0 is discarded, including on the forwarding path
        @(negedge clk);
        we = 1'b1; rd = 5'd0; wd = 32'hDEAD_BEEF; rs1 = 5'd0;
        #1;
        check("x0 fwd b", rd1_b, 32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check("x0 rd1 b", rd1_b, 32'h0);
        check("x0 rd1 n", rd1_n, 32'h0);

        // Forwarding: x7 is zero, write in flight with both ports on x7
        @(negedge clk);
        rs1 = 5'd7; rs2 = 5'd7;
        #1;
        check("x7 pre b", rd1_b, 32'h0);
        we = 1'b1; rd = 5'd7; wd = 32'h1234_5678;
        #1;
        check("fwd rd1 b", rd1_b, 32'h1234_5678);
        check("fwd rd2 b", rd2_b, 32'h1234_5678);
        check("nofwd rd1 n", rd1_n, 32'h0);
        check("nofwd rd2 n", rd2_n, 32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check("x7 post rd1 n", rd1_n, 32'h1234_5678);
        check("x7 post rd2 n", rd2_n, 32'h1234_5678);
        check("x7 post rd1 b", rd1_b, 32'h1234_5678);

        // Persistence over idle cycles
        rs1 = 5'd5; rs2 = 5'd31;
        repeat (5) @(posedge clk);
        #1;
        check("persist x5", rd1_b, 32'h0000_000F);
        check("persist x31", rd2_n, 32'hFFFF_FFFF);

        // Reset in READY drops ready immediately (asynchronous)
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst in ready b", {31'b0, ready_b}, 32'h0);
        check("rst in ready n", {31'b0, ready_n}, 32'h0);
        check("rst rd1 gated", rd1_b, 32'h0);

        // External write held through CLEAR, reset pulsed after 10 edges
        we = 1'b1; rd = 5'd3; wd = 32'hAAAA_5555; rs1 = 5'd3; rs2 = 5'd2;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid clr ready", {31'b0, ready_b}, 32'h0);
        check("mid clr rd1", rd1_b, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid clr rst ready", {31'b0, ready_b}, 32'h0);
        run_clear("clr2");
        we = 1'b0;
        #1;
        check("x3 ignored b", rd1_b, 32'h0);
        check("x3 ignored n", rd1_n, 32'h0);
        check("sp again", rd2_b, SP_VAL);
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("x5 recleared", rd1_b, 32'h0);
        check("x31 recleared", rd2_n, 32'h0);
        rs1 = 5'd7;
        #1;
        check("x7 recleared", rd1_b, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_init.md
REGFILE_INIT -- requirements
Module: regfile_init

Interface
REQ-001 Parameter: SP_INIT, 32'h0000_3FFC, value loaded into x2 (sp) by the clear sequence.
REQ-002 Parameter: BYPASS, 1, 1 = write-through forwarding from write port to read ports; 0 = no forwarding.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 Port: rs1  in  5  read address A.
REQ-006 Port: rs2  in  5  read address B.
REQ-007 Port: rd  in  5  write address.
REQ-008 Port: wd  in  32  write data (ALU result).
REQ-009 Port: we  in  1  write enable.
REQ-010 Port: rd1  out  32  read data A (ALU operand A).
REQ-011 Port: rd2  out  32  read data B (ALU operand B source).
REQ-012 Port: ready  out  1  1 = clear sequence done, file usable.

Function
REQ-013 Storage SHALL be 32 x 32-bit registers x0..x31; array not on reset net, only FSM/counter are.
REQ-014 FSM SHALL have two states: CLEAR and READY.
REQ-015 rst_n low SHALL force state = CLEAR, 5-bit counter = 1, ready = 0, immediately (async).
REQ-016 In CLEAR, each rising edge SHALL write reg[counter] <= (counter==2 ? SP_INIT : 0) and increment counter.
REQ-017 Edge that writes x31 SHALL move state to READY; ready = 1 from that edge on; counter SHALL NOT wrap to 0 within CLEAR.
REQ-018 ready SHALL rise on the 31st rising edge after rst_n deassertion (edges coincident with deassert not counted).
REQ-019 In CLEAR, we SHALL be ignored; no external write reaches the array.
REQ-020 While ready = 0, rd1 and rd2 SHALL be 32'h0.
REQ-021 In READY, rising edge with we=1 and rd!=0 SHALL write reg[rd] <= wd; rd=0 writes discarded.
REQ-022 Reads SHALL be combinational (zero latency): rsN==0 -> 0; else reg[rsN].
REQ-023 BYPASS=1: if ready, we=1, rd!=0 and rd==rsN, rdN SHALL equal wd in the same cycle; BYPASS=0: rdN shows old value until after the edge.
REQ-024 Both read ports SHALL be independent; rs1==rs2 gives identical data.
REQ-025 Reset asserted mid-CLEAR SHALL restart the sequence at counter = 1; asserted in READY SHALL drop ready and rerun full CLEAR.
REQ-026 Register contents SHALL persist indefinitely in READY absent writes; no other state change.

Reset
REQ-027 Output reset values: ready = 0, rd1 = 0, rd2 = 0, state = CLEAR, counter = 1.
REQ-028 After CLEAR completes, x0 = 0, x2 = SP_INIT, all other registers = 0.

Verification
REQ-029 Release rst_n, count edges -> ready = 0 for 30 edges, 1 after 31st; then rs1=2 -> rd1=32'h0000_3FFC, rs2=5 -> rd2=0.
REQ-030 READY, we=1 rd=5 wd=32'h0000_000F, one edge, we=0, rs1=5 -> rd1=32'h0000_000F; rd=31 wd=32'hFFFF_FFFF then rs2=31 -> rd2=32'hFFFF_FFFF.
REQ-031 READY, we=1 rd=0 wd=32'hDEAD_BEEF, one edge, rs1=0 -> rd1=0.
REQ-032 BYPASS=1, x7=0, we=1 rd=7 wd=32'h1234_5678 rs1=rs2=7 before edge -> rd1=rd2=32'h1234_5678 combinationally; BYPASS=0 same stimulus -> 0 until edge.
REQ-033 Reset release, we=1 rd=3 wd=32'hAAAA_5555 held during CLEAR, rst_n pulsed low after 10 edges -> ready low immediately, rises 31 edges after second release; rs1=3 -> rd1=0.
